// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode constants for the decode stage.
// Holds opcode values, ALUControl / ResultSrc / ImmSrc encodings and the
// packed control bundle produced by the decoder.
package riscv_pkg;

  // Major opcodes handled by the decoder
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // ImmSrc encodings
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // funct3 values
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LSW = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/imm_extend.sv
// imm_extend: combinational immediate generator for I/S/B/J formats.
// Ports:
//   Instr  [31:7] instruction bits that carry immediate fields
//   ImmSrc [1:0]  format select (IMM_I / IMM_S / IMM_B / IMM_J)
//   ImmExt [31:0] sign-extended immediate
module imm_extend
  import riscv_pkg::*;
(
  input  logic [31:7] Instr,
  input  logic [1:0]  ImmSrc,
  output logic [31:0] ImmExt
);

  always_comb begin
    ImmExt = '0;
    case (ImmSrc)
      IMM_I:   ImmExt = {{20{Instr[31]}}, Instr[31:20]};
      IMM_S:   ImmExt = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      IMM_B:   ImmExt = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25],
                         Instr[11:8], 1'b0};
      IMM_J:   ImmExt = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20],
                         Instr[30:21], 1'b0};
      default: ImmExt = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction-decode stage and ID/EX pipeline register.
// Decodes lw/sw/R-type/I-ALU/beq/jal into controls and an immediate, reads
// the register file through A1/A2 and registers everything into the E side.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-low reset
//   InstrD, PCD, PCPlus4D    instruction, its PC and PC+4 from IF/ID
//   ValidD                   InstrD is a real instruction
//   StallE, FlushE           hazard-unit hold / bubble-insert for ID/EX
//   A1, A2, RD1, RD2         register file read ports
//   RegWriteW, RdW, ResultW  write-back port, used for the bypass
//   *E outputs               ID/EX register contents
//
// Build option: DECODE_WB_BYPASS_EN adds the write-back -> RD1E/RD2E bypass.
// Without it, RD1E/RD2E always take RD1/RD2 and the hazard unit must stall
// one extra cycle when an ID source matches the WB destination.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              ValidD,
  input  logic              StallE,
  input  logic              FlushE,
  output logic [REG_AW-1:0] A1,
  output logic [REG_AW-1:0] A2,
  input  logic [XLEN-1:0]   RD1,
  input  logic [XLEN-1:0]   RD2,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   ResultW,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              ValidE,
  output logic              IllegalE
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = InstrD[6:0];
  assign funct3    = InstrD[14:12];
  assign funct7_b5 = InstrD[30];

  assign A1 = InstrD[19:15];
  assign A2 = InstrD[24:20];

  // ---------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------
  ctrl_t      ctl;
  logic [1:0] imm_src;

  always_comb begin
    ctl     = '0;
    imm_src = IMM_I;
    case (opcode)
      OP_LW: begin
        if (funct3 == F3_LSW) begin
          ctl.reg_write  = 1'b1;
          ctl.alu_src    = 1'b1;
          ctl.result_src = RES_MEM;
        end else begin
          ctl.illegal = 1'b1;
        end
      end
      OP_SW: begin
        imm_src = IMM_S;
        if (funct3 == F3_LSW) begin
          ctl.mem_write = 1'b1;
          ctl.alu_src   = 1'b1;
        end else begin
          ctl.illegal = 1'b1;
        end
      end
      OP_R: begin
        ctl.reg_write = 1'b1;
        case (funct3)
          F3_ADD:  ctl.alu_control = funct7_b5 ? ALU_SUB : ALU_ADD;
          F3_AND:  ctl.alu_control = ALU_AND;
          F3_OR:   ctl.alu_control = ALU_OR;
          F3_SLT:  ctl.alu_control = ALU_SLT;
          default: begin
            ctl.reg_write = 1'b0;
            ctl.illegal   = 1'b1;
          end
        endcase
      end
      OP_I: begin
        // funct7 bit 30 is part of the immediate here, so no sub variant.
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        case (funct3)
          F3_ADD:  ctl.alu_control = ALU_ADD;
          F3_AND:  ctl.alu_control = ALU_AND;
          F3_OR:   ctl.alu_control = ALU_OR;
          F3_SLT:  ctl.alu_control = ALU_SLT;
          default: begin
            ctl.reg_write = 1'b0;
            ctl.alu_src   = 1'b0;
            ctl.illegal   = 1'b1;
          end
        endcase
      end
      OP_BEQ: begin
        imm_src = IMM_B;
        if (funct3 == F3_BEQ) begin
          ctl.branch      = 1'b1;
          ctl.alu_control = ALU_SUB;
        end else begin
          ctl.illegal = 1'b1;
        end
      end
      OP_JAL: begin
        imm_src        = IMM_J;
        ctl.jump       = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.result_src = RES_PC4;
      end
      default: ctl.illegal = 1'b1;
    endcase
  end

  logic [31:0] imm_ext;

  imm_extend u_imm_extend (
    .Instr  (InstrD[31:7]),
    .ImmSrc (imm_src),
    .ImmExt (imm_ext)
  );

  // ---------------------------------------------------------------------
  // Operand selection (optional write-back bypass)
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] rd1_d, rd2_d;

`ifdef DECODE_WB_BYPASS_EN
  // The register file writes on the same edge that ID/EX samples, so a
  // matching WB write is forwarded here. x0 is never bypassed.
  logic byp1, byp2;
  assign byp1  = RegWriteW && (RdW != '0) && (RdW == A1);
  assign byp2  = RegWriteW && (RdW != '0) && (RdW == A2);
  assign rd1_d = byp1 ? ResultW : RD1;
  assign rd2_d = byp2 ? ResultW : RD2;
`else
  logic unused_wb;
  assign unused_wb = ^{RegWriteW, RdW, ResultW};
  assign rd1_d = RD1;
  assign rd2_d = RD2;
`endif

  // ---------------------------------------------------------------------
  // ID/EX next-state
  // ---------------------------------------------------------------------
  ctrl_t             ctl_d, ctl_q;
  logic              valid_d, valid_q;
  logic [REG_AW-1:0] rd_d;

  always_comb begin
    ctl_d   = ctl;
    valid_d = ValidD;
    // A bubble must not write, branch, jump or raise illegal.
    if (!ValidD) begin
      ctl_d.reg_write = 1'b0;
      ctl_d.mem_write = 1'b0;
      ctl_d.branch    = 1'b0;
      ctl_d.jump      = 1'b0;
      ctl_d.illegal   = 1'b0;
    end
  end

  // sw and beq have no destination; a zero RdE keeps forwarding quiet.
  assign rd_d = ((opcode == OP_SW) || (opcode == OP_BEQ)) ? '0 : InstrD[11:7];

  logic [XLEN-1:0]   rd1_q, rd2_q, imm_q, pc_q, pc4_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rdx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q   <= '0;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rdx_q   <= '0;
    end else if (FlushE) begin
      ctl_q   <= '0;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rdx_q   <= '0;
    end else if (!StallE) begin
      ctl_q   <= ctl_d;
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_ext;
      pc_q    <= PCD;
      pc4_q   <= PCPlus4D;
      rs1_q   <= A1;
      rs2_q   <= A2;
      rdx_q   <= rd_d;
    end
  end

  assign RegWriteE   = ctl_q.reg_write;
  assign MemWriteE   = ctl_q.mem_write;
  assign JumpE       = ctl_q.jump;
  assign BranchE     = ctl_q.branch;
  assign ALUSrcE     = ctl_q.alu_src;
  assign ResultSrcE  = ctl_q.result_src;
  assign ALUControlE = ctl_q.alu_control;
  assign IllegalE    = ctl_q.illegal;
  assign ValidE      = valid_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ImmExtE     = imm_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc4_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rdx_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, StallE, FlushE;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ValidE, IllegalE;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ValidE(ValidE), .IllegalE(IllegalE)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        regw, memw, jump, branch, alusrc;
    logic [1:0]  ressrc;
    logic [2:0]  aluctl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        valid, illegal;
    logic        chk_imm;
  } exp_t;

  function automatic exp_t mk(input logic regw, memw, jump, branch, alusrc,
                              input logic [1:0] ressrc, input logic [2:0] aluctl,
                              input logic [31:0] imm, input logic [4:0] rs1, rs2, rd);
    exp_t e;
    e = '{default: '0};
    e.regw = regw; e.memw = memw; e.jump = jump; e.branch = branch;
    e.alusrc = alusrc; e.ressrc = ressrc; e.aluctl = aluctl; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.valid = 1'b1; e.chk_imm = 1'b1;
    return e;
  endfunction

  function automatic exp_t zero_e();
    exp_t e;
    e = '{default: '0};
    e.chk_imm = 1'b1;
    return e;
  endfunction

  task automatic check_e(input string tag, input exp_t e);
    chk({tag, ".RegWriteE"},   32'(RegWriteE),   32'(e.regw));
    chk({tag, ".MemWriteE"},   32'(MemWriteE),   32'(e.memw));
    chk({tag, ".JumpE"},       32'(JumpE),       32'(e.jump));
    chk({tag, ".BranchE"},     32'(BranchE),     32'(e.branch));
    chk({tag, ".ALUSrcE"},     32'(ALUSrcE),     32'(e.alusrc));
    chk({tag, ".ResultSrcE"},  32'(ResultSrcE),  32'(e.ressrc));
    chk({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(e.aluctl));
    chk({tag, ".RD1E"},        RD1E,             e.rd1);
    chk({tag, ".RD2E"},        RD2E,             e.rd2);
    if (e.chk_imm) chk({tag, ".ImmExtE"}, ImmExtE, e.imm);
    chk({tag, ".PCE"},         PCE,              e.pc);
    chk({tag, ".PCPlus4E"},    PCPlus4E,         e.pc4);
    chk({tag, ".Rs1E"},        32'(Rs1E),        32'(e.rs1));
    chk({tag, ".Rs2E"},        32'(Rs2E),        32'(e.rs2));
    chk({tag, ".RdE"},         32'(RdE),         32'(e.rd));
    chk({tag, ".ValidE"},      32'(ValidE),      32'(e.valid));
    chk({tag, ".IllegalE"},    32'(IllegalE),    32'(e.illegal));
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid,
                       input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    InstrD = instr; ValidD = valid; PCD = pc; PCPlus4D = pc + 32'd4;
    RD1 = r1; RD2 = r2;
  endtask

  task automatic apply(input logic [31:0] instr, input logic valid,
                       input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    drive(instr, valid, pc, r1, r2);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t with_ops(input exp_t e0, input logic [31:0] pc,
                                    input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e = e0; e.pc = pc; e.pc4 = pc + 32'd4; e.rd1 = r1; e.rd2 = r2;
    return e;
  endfunction

  exp_t e_addi, e_sw, e;

  initial begin
    rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    drive(32'h0070_0293, 1'b1, 32'h100, 32'h11, 32'h22);
    #12;
    check_e("reset", zero_e());
    @(negedge clk);
    rst = 1'b1;

    // addi x5,x0,7
    e_addi = with_ops(mk(1,0,0,0,1,2'b00,3'b000,32'd7,5'd0,5'd7,5'd5), 32'h100, 32'h11, 32'h22);
    apply(32'h0070_0293, 1'b1, 32'h100, 32'h11, 32'h22);
    check_e("addi", e_addi);

    // sw x6,12(x5)
    e_sw = with_ops(mk(0,1,0,0,1,2'b00,3'b000,32'd12,5'd5,5'd6,5'd0), 32'h104, 32'h33, 32'h44);
    apply(32'h0062_A623, 1'b1, 32'h104, 32'h33, 32'h44);
    check_e("sw", e_sw);

    // beq x1,x2,-8
    apply(32'hFE20_8CE3, 1'b1, 32'h108, 32'h5, 32'h6);
    check_e("beq", with_ops(mk(0,0,0,1,0,2'b00,3'b001,32'hFFFF_FFF8,5'd1,5'd2,5'd0), 32'h108, 32'h5, 32'h6));

    // R-type add/sub/and/or/slt (immediate is don't-care)
    e = with_ops(mk(1,0,0,0,0,2'b00,3'b000,32'd0,5'd1,5'd2,5'd3), 32'h10C, 32'h1, 32'h2);
    e.chk_imm = 1'b0;
    apply(32'h0020_81B3, 1'b1, 32'h10C, 32'h1, 32'h2);
    check_e("add", e);
    e.aluctl = 3'b001;
    apply(32'h4020_81B3, 1'b1, 32'h10C, 32'h1, 32'h2);
    check_e("sub", e);
    e.aluctl = 3'b010; e.rd = 5'd4;
    apply(32'h0020_F233, 1'b1, 32'h10C, 32'h1, 32'h2);
    check_e("and", e);
    e.aluctl = 3'b011;
    apply(32'h0020_E233, 1'b1, 32'h10C, 32'h1, 32'h2);
    check_e("or", e);
    e.aluctl = 3'b101;
    apply(32'h0020_A233, 1'b1, 32'h10C, 32'h1, 32'h2);
    check_e("slt", e);

    // andi x4,x1,-1
    apply(32'hFFF0_F213, 1'b1, 32'h110, 32'h7, 32'h8);
    check_e("andi", with_ops(mk(1,0,0,0,1,2'b00,3'b010,32'hFFFF_FFFF,5'd1,5'd31,5'd4), 32'h110, 32'h7, 32'h8));

    // lw x7,-4(x2)
    apply(32'hFFC1_2383, 1'b1, 32'h114, 32'h9, 32'hA);
    check_e("lw", with_ops(mk(1,0,0,0,1,2'b01,3'b000,32'hFFFF_FFFC,5'd2,5'd28,5'd7), 32'h114, 32'h9, 32'hA));

    // jal x1,+16
    apply(32'h0100_00EF, 1'b1, 32'h118, 32'hB, 32'hC);
    check_e("jal", with_ops(mk(1,0,1,0,0,2'b10,3'b000,32'd16,5'd0,5'd16,5'd1), 32'h118, 32'hB, 32'hC));

    // unsupported opcode 0x7F
    e = with_ops(zero_e(), 32'h11C, 32'hD, 32'hE);
    e.valid = 1'b1; e.illegal = 1'b1; e.chk_imm = 1'b0;
    apply(32'h0000_007F, 1'b1, 32'h11C, 32'hD, 32'hE);
    check_e("ill_op", e);

    // unsupported I-ALU funct3 (001)
    e.rs1 = 5'd1; e.rs2 = 5'd1; e.rd = 5'd1;
    apply(32'h0010_9093, 1'b1, 32'h11C, 32'hD, 32'hE);
    check_e("ill_f3", e);

    // bubbles: lw and 0x7F with ValidD=0
    e = with_ops(mk(0,0,0,0,1,2'b01,3'b000,32'hFFFF_FFFC,5'd2,5'd28,5'd7), 32'h120, 32'h1, 32'h2);
    e.valid = 1'b0;
    apply(32'hFFC1_2383, 1'b0, 32'h120, 32'h1, 32'h2);
    check_e("bubble_lw", e);
    apply(32'h0000_007F, 1'b0, 32'h124, 32'h0, 32'h0);
    chk("bubble_ill.IllegalE", 32'(IllegalE), 32'd0);
    chk("bubble_ill.ValidE",   32'(ValidE),   32'd0);

    // write-back bypass
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEAD_BEEF;
    apply(32'h0002_8313, 1'b1, 32'h128, 32'h0, 32'h77);
`ifdef DECODE_WB_BYPASS_EN
    chk("byp_rs1.RD1E", RD1E, 32'hDEAD_BEEF);
`else
    chk("byp_rs1.RD1E", RD1E, 32'h0);
`endif
    chk("byp_rs1.RD2E", RD2E, 32'h77);
    chk("byp_rs1.Rs1E", 32'(Rs1E), 32'd5);

    RdW = 5'd6;
    apply(32'h0062_A623, 1'b1, 32'h12C, 32'h31, 32'h32);
    chk("byp_rs2.RD1E", RD1E, 32'h31);
`ifdef DECODE_WB_BYPASS_EN
    chk("byp_rs2.RD2E", RD2E, 32'hDEAD_BEEF);
`else
    chk("byp_rs2.RD2E", RD2E, 32'h32);
`endif

    RdW = 5'd0;
    apply(32'h0000_0313, 1'b1, 32'h130, 32'h55, 32'h66);
    chk("byp_x0.RD1E", RD1E, 32'h55);
    chk("byp_x0.RD2E", RD2E, 32'h66);

    RegWriteW = 1'b0; RdW = 5'd5;
    apply(32'h0002_8313, 1'b1, 32'h134, 32'h12, 32'h13);
    chk("byp_nowe.RD1E", RD1E, 32'h12);
    RdW = 5'd0; ResultW = '0;

    // stall holds for two cycles, then flush wins over stall
    apply(32'h0070_0293, 1'b1, 32'h100, 32'h11, 32'h22);
    check_e("pre_stall", e_addi);
    @(negedge clk);
    StallE = 1'b1;
    drive(32'h0062_A623, 1'b1, 32'h200, 32'h99, 32'h98);
    @(posedge clk); #1;
    check_e("stall1", e_addi);
    @(posedge clk); #1;
    check_e("stall2", e_addi);
    @(negedge clk);
    FlushE = 1'b1;
    @(posedge clk); #1;
    check_e("flush_stall", zero_e());
    @(negedge clk);
    StallE = 1'b0;
    @(posedge clk); #1;
    check_e("flush_only", zero_e());
    @(negedge clk);
    FlushE = 1'b0;

    // asynchronous reset mid-stream
    apply(32'h0070_0293, 1'b1, 32'h100, 32'h11, 32'h22);
    check_e("pre_rst", e_addi);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_e("rst_async", zero_e());
    @(posedge clk); #1;
    check_e("rst_hold", zero_e());
    @(negedge clk);
    rst = 1'b1;
    drive(32'h0062_A623, 1'b1, 32'h104, 32'h33, 32'h44);
    @(posedge clk); #1;
    check_e("rst_release", e_sw);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I pipeline; sits between the IF/ID register and the execute stage.
- Drives the register file's two read addresses and consumes its two read-data values.
- Decodes control signals and the sign-extended immediate, then registers everything into the ID/EX pipeline register.
- Supports flush and stall from the hazard unit, plus a write-back bypass because the register file writes on the clock edge.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- InstrD  in  32  instruction from IF/ID.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PC+4 of InstrD.
- ValidD  in  1  InstrD is a real instruction (not a bubble).
- StallE  in  1  hold all ID/EX contents.
- FlushE  in  1  load a bubble into ID/EX.
- A1  out  5  register file read address 1, combinational from InstrD[19:15].
- A2  out  5  register file read address 2, combinational from InstrD[24:20].
- RD1  in  32  register file read data 1.
- RD2  in  32  register file read data 2.
- RegWriteW  in  1  write-back write enable (same signal drives the register file WE3).
- RdW  in  5  write-back destination.
- ResultW  in  32  write-back data.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered controls.
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered operands.
- Rs1E, Rs2E, RdE  out  5 each  registered register indices, used by the forwarding unit.
- ValidE  out  1  ID/EX holds a real instruction.
- IllegalE  out  1  registered unsupported-opcode flag.

Behaviour:
- Decoded opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011: add, sub, and, or, slt
  - I-ALU 0010011: addi, andi, ori, slti
  - beq 1100011
  - jal 1101111
- Immediate formats:
  - I: {20{i[31]}, i[31:20]}
  - S: {20{i[31]}, i[31:25], i[11:7]}
  - B: {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}
  - J: {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}
- ALU decode:
  - R-type uses sub only when funct7[5]=1.
  - I-ALU with funct3 000 is always add.
  - beq uses sub.
  - lw, sw and jal use add.
- Unsupported opcode or funct3: all write/branch/jump controls are 0 and the illegal flag is 1. The instruction still propagates with its ValidE value.
- Rs1E and Rs2E are loaded from the instruction fields regardless of format. RdE is loaded as 0 for sw and beq.
- Latency: one cycle. Decoded signals are sampled at the rising clk edge into the E outputs.
- Reset (rst=0, asynchronous): every E output is 0 immediately and stays 0 while rst=0. All-zero is a legal bubble.
- Priority at each edge: rst, then FlushE, then StallE, then normal load.
  - FlushE=1: all E outputs become 0, even if StallE=1.
  - StallE=1 (no flush): all E outputs hold.
- ValidD=0: the loaded entry has ValidE=0, RegWriteE=0, MemWriteE=0, BranchE=0, JumpE=0, IllegalE=0.
- Write-back bypass:
  - Condition: RegWriteW=1, RdW!=0 and RdW==A1.
  - Effect: RD1E loads ResultW instead of RD1. Same rule for A2/RD2E.
  - RdW=0 never bypasses, so x0 always reads 0 from the register file.
- Deassertion of rst is handled on the next rising edge; there is no partial state.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: the write-back bypass above is present.
- Undefined: RD1E and RD2E always load RD1 and RD2. The hazard unit must then stall one extra cycle on an ID/WB register match.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - ALUControl encodings
  - ResultSrc encodings
  - ImmSrc encodings: IMM_I, IMM_S, IMM_B, IMM_J
- One sub-module, imm_extend: combinational, inputs InstrD[31:7] and ImmSrc, output ImmExt.
- Control decoding and the ID/EX register stay in decode_stage.

Test Plan:
- Reset: hold rst=0 mid-stream with a valid instruction loaded -> all E outputs 0 asynchronously; after release, the first edge loads the new InstrD.
- addi x5,x0,7 (0x00700293) -> next edge: RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=7, RdE=5, ResultSrcE=00.
- sw x6,12(x5) (0x0062A623) -> MemWriteE=1, RegWriteE=0, ImmExtE=12, Rs1E=5, Rs2E=6, RdE=0.
- beq x1,x2,-8 (0xFE208CE3) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8.
- Bypass: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF, InstrD reads rs1=5, RD1=0 -> RD1E=0xDEADBEEF. With RdW=0 -> RD1E=RD1. With the macro undefined -> RD1E=0.
- Stall/flush: StallE=1 for 2 cycles -> E outputs unchanged. StallE=1 and FlushE=1 together -> all E outputs 0. Opcode 0x7F -> IllegalE=1, RegWriteE=0.
